serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. Processes one bit per clock through a single gate-level full-adder slice built from the team's two-input primitives: inverter, and, or, xor.
- Replaces a wide ripple-carry chain where area matters. The result feeds the 7-segment display path.
- Start/busy/done handshake. The result is held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when the result is valid
- s  output  WIDTH  result, registered
- co  output  1  carry out; in subtract mode 1 = no borrow
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - s, co, ovf, busy, done, bit counter, carry flop and shift registers all go to 0.
  - Reset asserted mid-operation aborts the operation. No done is issued.
- State machine, encoded as IDLE, RUN, DONE:
  - IDLE: if start=1 at edge E0:
    - Load A shift register with a.
    - Load B shift register with b XOR {WIDTH{sub}}.
    - Carry flop = sub; counter = 0; ovf = 0; go to RUN.
    - s and co keep their previous values until the first RUN edge.
  - RUN: each edge computes sum = A0^B0^c and cout = (A0&B0)|(c&(A0^B0)) through the gate primitives.
    - Shift sum into the MSB of the result register (result fills LSB-first).
    - Shift A and B right by one.
    - c <= cout; counter increments.
  - RUN exit: at edge EW (the WIDTH-th RUN edge):
    - Register co = final cout.
    - Register ovf = (carry into the MSB) XOR (final cout).
    - Go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE at edge EW+1.
- Latency: done is high in the cycle after edge E(WIDTH). The next start is accepted at the first IDLE cycle, giving a throughput of one operation per WIDTH+2 cycles.
- busy=1 from the cycle after E0 through the DONE cycle.
- s is not valid while busy. s, co and ovf are stable from the done cycle until the next accepted start.
- start asserted in RUN or DONE is ignored. It is not queued.
- Operands and sub may change freely after E0 without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH+1) bits wide and does not wrap within an operation.

Optional Feature:
- Macro SERIAL_ADDSUB_ACC_EN.
- Defined:
  - Adds input port acc (1 bit).
  - When start=1 and acc=1 in IDLE, the A shift register loads the current s instead of a, giving a running accumulation. b and sub behave as normal.
  - After reset the accumulated value starts from 0.
- Not defined:
  - No acc port.
  - A always loads from a.

Test Plan (WIDTH=8):
1. start, a=0x3C, b=0x05, sub=0 -> done high in the 9th cycle after the start edge; s=0x41, co=0, ovf=0; busy low the following cycle.
2. a=0xFF, b=0x01, sub=0 -> s=0x00, co=1, ovf=0. Then a=0x7F, b=0x01 -> s=0x80, co=0, ovf=1.
3. sub=1: a=0x05, b=0x07 -> s=0xFE, co=0 (borrow). a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1.
4. start pulsed again 3 cycles into RUN with different operands -> ignored; first result unchanged; exactly one done pulse.
5. reset asserted asynchronously 4 cycles into RUN -> all outputs 0 immediately; no done. A fresh start after release with a=0x10, b=0x20 -> s=0x30.
6. With SERIAL_ADDSUB_ACC_EN defined:
   - start acc=0, a=0x10, b=0x01 -> s=0x11.
   - Then acc=1, b=0x02 -> s=0x13.
   - Then acc=1, sub=1, b=0x03 -> s=0x10.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, one result bit per clock, start/busy/done handshake.
// Define SERIAL_ADDSUB_ACC_EN to add the acc input (operand A reloads from the held result).
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
`ifdef SERIAL_ADDSUB_ACC_EN
  input  logic             acc,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_co;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_p;
  logic             w_g;
  logic             w_pc;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_a_load;

  // Full-adder slice built from two-input gates only.
  xor u_xor_p   (w_p,    r_a[0], r_b[0]);
  xor u_xor_sum (w_sum,  w_p,    r_c);
  and u_and_g   (w_g,    r_a[0], r_b[0]);
  and u_and_pc  (w_pc,   w_p,    r_c);
  or  u_or_cout (w_cout, w_g,    w_pc);

  // Operand A source: the external input, or the held result when accumulating.
  always_comb begin
    w_a_load = a;
`ifdef SERIAL_ADDSUB_ACC_EN
    if (acc) begin
      w_a_load = r_s;
    end else begin
      w_a_load = a;
    end
`endif
  end

  // Control FSM and datapath; subtraction is a + ~b + 1 with the carry flop seeded by sub.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_s     <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_c     <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= w_a_load;
            r_b     <= b ^ {WIDTH{sub}};
            r_c     <= sub;
            r_cnt   <= {CW{1'b0}};
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_s   <= {w_sum, r_s[WIDTH-1:1]};
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          // r_c still holds the carry into the MSB on the last slice.
          if (r_cnt == LAST_BIT) begin
            r_co    <= w_cout;
            r_ovf   <= r_c ^ w_cout;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule
